multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS-subset core. It sequences the shared datapath (PC, IR, register file, single ALU, immediate extender, unified memory port) one instruction at a time. It drives the extender mode select `ext_type` (2'b11 = zero-extend, 2'b00 = sign-extend) together with every mux select and write enable. Memory accesses use a req/ready handshake, so the controller stalls for variable memory latency.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- zero  in  1  ALU zero flag, registered by datapath
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR load
- pc_we  out  1  PC load
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_ctrl  out  3  000 and, 001 or, 010 add, 011 xor, 100 lui, 110 sub, 111 slt
- ext_type  out  2  11 zero-extend, 00 sign-extend
- illegal  out  1  one-cycle pulse on an unsupported op or funct
- state  out  4  current state, for debug

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, WB_R, WB_I.
- Outputs are decoded from the registered state. The only exceptions are ir_we and pc_we in FETCH, which also depend on mem_ready. Any output not listed for a state is 0.
- RESET: all outputs 0. Always goes to FETCH.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00.
  - While mem_ready=1: ir_we=1, pc_we=1, and the next state is DECODE. Otherwise stays in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut).
  - Next state by op:
    - 000000 → EXEC_R
    - 100011 or 101011 → MEM_ADDR
    - 000100 or 000101 → BRANCH
    - 000010 → JUMP
    - 001000, 001001, 001010, 001100, 001101, 001110, 001111 → EXEC_I
    - any other op → FETCH, with illegal=1 for this cycle
- EXEC_R:
  - Drives alu_src_a=1, alu_src_b=00.
  - funct → alu_ctrl: 100000/100001 → add, 100010/100011 → sub, 100100 → and, 100101 → or, 100110 → xor, 101010 → slt.
  - Valid funct → WB_R. Any other funct → FETCH with illegal=1.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- EXEC_I:
  - Drives alu_src_a=1, alu_src_b=10.
  - op → alu_ctrl: addi/addiu → add, slti → slt, andi → and, ori → or, xori → xor, lui → lui.
  - Then WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1. Stays until mem_ready, then MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Stays until mem_ready, then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01.
  - pc_we = zero for beq, ~zero for bne.
  - Then FETCH.
- JUMP: pc_we=1, pc_src=10. Then FETCH.
- ext_type:
  - 2'b11 when op is andi, ori, xori or lui, and the state is neither RESET nor FETCH.
  - 2'b00 otherwise, including RESET and FETCH.

## Timing
- Reset: asserting rst_n low forces state=RESET immediately (asynchronous), from any state. An outstanding memory request is abandoned with no write; mem_req drops immediately.
- Reset release: the first rising edge after release moves RESET → FETCH.
- Latency with mem_ready high in the same cycle as each request:
  - R-type and I-type ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, bne, j: 3 cycles
- Each stall cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Handshake:
  - While mem_ready=0, mem_req, mem_we and iord stay stable.
  - mem_ready is ignored in states where mem_req=0.
- Illegal instruction: illegal is high for exactly one cycle (DECODE or EXEC_R), no register or PC write occurs, and the next state is FETCH.
- pc_we is never asserted twice for one instruction, except that a taken branch or jump updates the PC once more after its FETCH.

## Test plan
- Reset: hold rst_n=0, then release. All outputs are 0 in RESET. The next cycle is FETCH with mem_req=1, iord=0. Pulsing rst_n low during MEM_WR drops mem_req and mem_we in the same cycle.
- addi then andi, mem_ready always 1:
  - addi (op 001000): states FETCH, DECODE, EXEC_I, WB_I; ext_type=00, alu_ctrl=010.
  - andi (op 001100): ext_type=11 in DECODE through WB_I, alu_ctrl=000, reg_we=1 only in WB_I.
- lw with mem_ready held low for 3 cycles in MEM_RD: MEM_RD lasts 4 cycles with mem_req and iord stable, then MEM_WB with mem_to_reg=1. Total 8 cycles.
- beq with zero=1: pc_we=1 and pc_src=01 in BRANCH. beq with zero=0: pc_we=0. bne inverts both cases.
- R-type funct 100101: alu_ctrl=001 and reg_dst=1 in WB_R. funct 000000: illegal pulses in EXEC_R, reg_we stays 0, next state is FETCH.
- op 111111: illegal pulses in DECODE and the next state is FETCH. j (op 000010): pc_src=10 and pc_we=1, instruction completes in 3 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences the shared datapath
// one instruction at a time, stalling on the memory req/ready handshake.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] ext_type,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_WB_R     = 4'd11,
        S_WB_I     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state, nxt_state;

    // State register; async reset drops any outstanding memory request at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_RESET;
        else        cur_state <= nxt_state;
    end

    assign state = STATE_W'(cur_state);

    // Next-state and Moore decode (FETCH ir_we/pc_we also follow mem_ready)
    always_comb begin
        nxt_state  = cur_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        ext_type   = 2'b00;
        illegal    = 1'b0;

        unique case (cur_state)
            S_RESET: nxt_state = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (op)
                    OP_RTYPE:       nxt_state = S_EXEC_R;
                    OP_LW, OP_SW:   nxt_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
                    OP_J:           nxt_state = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: nxt_state = S_EXEC_I;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                nxt_state = S_WB_R;
                case (funct)
                    6'b100000, 6'b100001: alu_ctrl = ALU_ADD;
                    6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
                    6'b100100:            alu_ctrl = ALU_AND;
                    6'b100101:            alu_ctrl = ALU_OR;
                    6'b100110:            alu_ctrl = ALU_XOR;
                    6'b101010:            alu_ctrl = ALU_SLT;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_WB_R: begin
                reg_we    = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_WB_I;
                case (op)
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_XORI: alu_ctrl = ALU_XOR;
                    OP_LUI:  alu_ctrl = ALU_LUI;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_WB_I: begin
                reg_we    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                nxt_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_we     = (op == OP_BEQ) ? zero : ~zero;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_we     = 1'b1;
                pc_src    = 2'b10;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Logical immediates zero-extend once the IR holds the instruction
        if (cur_state != S_RESET && cur_state != S_FETCH &&
            (op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == OP_LUI))
            ext_type = 2'b11;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes, stalls and reset
// through the FSM and checks decoded controls against hand-computed values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] ext_type;
    logic       illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_type(ext_type),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] br_op  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       br_z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       br_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_outs", 32'({mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                             mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, ext_type, illegal}), 0);
        rst_n = 1'b1;

        // FETCH with a one-cycle stall
        step();
        chk("fetch_state", 32'(state), 1);
        chk("fetch_req_iord", 32'({mem_req, iord}), 32'b10);
        chk("fetch_stall_irwe", 32'({ir_we, pc_we}), 0);
        step();
        chk("fetch_stall_hold", 32'(state), 1);
        mem_ready = 1'b1; #1;
        chk("fetch_ready_we", 32'({ir_we, pc_we}), 32'b11);

        // addi
        op = 6'b001000;
        step(); chk("addi_decode", 32'(state), 2);
        chk("addi_dec_srcb", 32'(alu_src_b), 3);
        step(); chk("addi_exec", 32'(state), 4);
        chk("addi_ext_alu", 32'({ext_type, alu_ctrl}), 32'b00_010);
        step(); chk("addi_wb", 32'(state), 12);
        chk("addi_wb_we", 32'({reg_we, reg_dst, mem_to_reg}), 32'b100);
        step(); chk("addi_back_fetch", 32'(state), 1);

        // andi
        op = 6'b001100; #1;
        chk("andi_fetch_ext", 32'(ext_type), 0);
        step(); chk("andi_dec_ext_we", 32'({ext_type, reg_we}), 32'b11_0);
        step(); chk("andi_exec", 32'({state, alu_ctrl, ext_type, reg_we}), 32'b0100_000_11_0);
        step(); chk("andi_wb", 32'({state, ext_type, reg_we}), 32'b1100_11_1);
        step(); chk("andi_back_fetch", 32'(state), 1);

        // lw with three stall cycles in MEM_RD
        op = 6'b100011;
        step(); chk("lw_decode", 32'(state), 2);
        step(); chk("lw_addr", 32'({state, alu_src_a, alu_src_b, alu_ctrl}), 32'b0101_1_10_010);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("lw_memrd_%0d", i), 32'({state, mem_req, iord, mem_we, reg_we}),
                32'b0110_1_1_0_0);
            if (i == 3) mem_ready = 1'b1;
        end
        step(); chk("lw_memwb", 32'({state, reg_we, reg_dst, mem_to_reg}), 32'b0111_1_0_1);
        step(); chk("lw_back_fetch", 32'(state), 1);

        // beq/bne with zero set and clear
        for (int k = 0; k < 4; k++) begin
            op = br_op[k];
            step(); chk($sformatf("br%0d_decode", k), 32'(state), 2);
            zero = br_z[k];
            step();
            chk($sformatf("br%0d_branch", k), 32'({state, pc_src, alu_ctrl}), 32'b1001_01_110);
            chk($sformatf("br%0d_pcwe", k), 32'(pc_we), 32'(br_exp[k]));
            step(); chk($sformatf("br%0d_fetch", k), 32'(state), 1);
        end
        zero = 1'b0;

        // R-type or
        op = 6'b000000; funct = 6'b100101;
        step(); chk("or_decode", 32'(state), 2);
        step(); chk("or_exec", 32'({state, alu_ctrl, alu_src_a, alu_src_b}), 32'b0011_001_1_00);
        step(); chk("or_wb", 32'({state, reg_we, reg_dst}), 32'b1011_1_1);
        step(); chk("or_fetch", 32'(state), 1);

        // R-type with illegal funct
        funct = 6'b000000;
        step(); chk("badf_decode", 32'({state, illegal}), 32'b0010_0);
        step(); chk("badf_exec", 32'({state, illegal, reg_we, pc_we}), 32'b0011_1_0_0);
        step(); chk("badf_fetch", 32'({state, illegal}), 32'b0001_0);

        // illegal opcode
        op = 6'b111111;
        step(); chk("badop_decode", 32'({state, illegal, reg_we, pc_we}), 32'b0010_1_0_0);
        step(); chk("badop_fetch", 32'({state, illegal}), 32'b0001_0);

        // jump
        op = 6'b000010;
        step(); chk("j_decode", 32'(state), 2);
        step(); chk("j_jump", 32'({state, pc_we, pc_src}), 32'b1010_1_10);
        step(); chk("j_fetch", 32'(state), 1);

        // sw stalled in MEM_WR, then reset mid-cycle
        op = 6'b101011;
        step(); chk("sw_decode", 32'(state), 2);
        step(); chk("sw_addr", 32'(state), 5);
        mem_ready = 1'b0;
        step(); chk("sw_memwr", 32'({state, mem_req, mem_we, iord}), 32'b1000_1_1_1);
        step(); chk("sw_memwr_hold", 32'({state, mem_req, mem_we, iord}), 32'b1000_1_1_1);
        #2 rst_n = 1'b0;
        #1 chk("sw_rst_drop", 32'({state, mem_req, mem_we}), 32'b0000_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step(); chk("post_rst_fetch", 32'({state, mem_req, iord}), 32'b0001_1_0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
